sqrt_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit integer square-root unit among N_REQ requesters. Each requester has a valid/ready request port and a valid/ready response port. The block owns the unit's start/done handshake. It sits between client logic and the single sqrt instance; only one operation is ever in flight.

---
 rtl/sqrt_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/sqrt_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sqrt_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_arb_pkg
// Purpose  : Shared types and helpers for the sqrt_arbiter block.
//            Provides the FSM state type, the data width and the width of a
//            requester index.
// Revision : 1.0 - initial release
// ============================================================================
package sqrt_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Bits needed to hold a requester index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : sqrt_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            request found searching upward from ptr, wrapping at N_REQ-1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Scan offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        int k;
        k       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            k = int'(ptr) + off;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (req[IDX_W'(k)]) begin
                gnt_idx = IDX_W'(k);
                gnt_any = 1'b1;
            end
        end
        gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_arbiter
// Purpose  : Round-robin scheduler sharing one 8-bit integer square-root unit
//            among N_REQ requesters, one operation in flight at a time.
//            Optional feature macro: SQRT_ARB_TIMEOUT_EN (adds a WAIT-state
//            watchdog and the resp_err output).
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_x,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    input  logic [N_REQ-1:0]        resp_ready,
`ifdef SQRT_ARB_TIMEOUT_EN
    output logic                    resp_err,
`endif
    output logic                    sqrt_start,
    output logic [DATA_W-1:0]       sqrt_x,
    input  logic                    sqrt_done,
    input  logic [DATA_W-1:0]       sqrt_y,
    output logic                    busy
);

    localparam int IDX_W = idx_width(N_REQ);

    // Reject unsupported configurations at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("sqrt_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    sqrt_start_q, sqrt_start_d;
    logic [DATA_W-1:0]       sqrt_x_q, sqrt_x_d;
    logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]       resp_data_q, resp_data_d;

    logic [N_REQ-1:0]        w_gnt;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_gnt_any;
    logic [DATA_W-1:0]       w_opnd [N_REQ];
    logic                    w_resp_hs;
    logic                    w_timeout;
    logic [IDX_W-1:0]        w_ptr_next;

    // Split the flat operand bus into one word per requester.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_opnd[gi] = req_x[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_resp_hs  = (state_q == ST_RESP) && resp_ready[grant_q];
    assign w_ptr_next = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q, resp_err_d;

    // A completion in the same cycle as the last allowed WAIT cycle wins.
    assign w_timeout = (state_q == ST_WAIT) && !sqrt_done && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register and all datapath flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            sqrt_start_q <= 1'b0;
            sqrt_x_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            sqrt_start_q <= sqrt_start_d;
            sqrt_x_q     <= sqrt_x_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef SQRT_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    // Next-state logic; sqrt_done only matters while waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_gnt_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (sqrt_done || w_timeout) state_d = ST_RESP;
            ST_RESP:  if (w_resp_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: accept latch, result capture, pointer advance.
    always_comb begin
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        sqrt_start_d = 1'b0;
        sqrt_x_d     = sqrt_x_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
`ifdef SQRT_ARB_TIMEOUT_EN
        cnt_d        = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
        resp_err_d   = resp_err_q;
`endif
        if (state_q == ST_IDLE && w_gnt_any) begin
            grant_d      = w_gnt_idx;
            sqrt_x_d     = w_opnd[w_gnt_idx];
            sqrt_start_d = 1'b1;
        end
        if (state_q == ST_WAIT && sqrt_done) begin
            resp_valid_d = N_REQ'(1) << grant_q;
            resp_data_d  = sqrt_y;
`ifdef SQRT_ARB_TIMEOUT_EN
            resp_err_d   = 1'b0;
`endif
        end else if (w_timeout) begin
            resp_valid_d = N_REQ'(1) << grant_q;
            resp_data_d  = '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            resp_err_d   = 1'b1;
`endif
        end
        if (w_resp_hs) begin
            resp_valid_d = '0;
            ptr_d        = w_ptr_next;
`ifdef SQRT_ARB_TIMEOUT_EN
            resp_err_d   = 1'b0;
`endif
        end
    end

    // Outputs: accept is offered only while idle; the rest come from flops.
    always_comb begin
        req_ready  = (state_q == ST_IDLE) ? w_gnt : '0;
        busy       = (state_q != ST_IDLE);
        sqrt_start = sqrt_start_q;
        sqrt_x     = sqrt_x_q;
        resp_valid = resp_valid_q;
        resp_data  = resp_data_q;
`ifdef SQRT_ARB_TIMEOUT_EN
        resp_err   = resp_err_q;
`endif
    end

endmodule : sqrt_arbiter
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_arbiter
// Purpose  : Self-checking bench for sqrt_arbiter with a behavioural sqrt unit
//            and a response scoreboard. Build with SQRT_ARB_TIMEOUT_EN to
//            also exercise the watchdog (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [7:0]     resp_data;
    logic [N-1:0]   resp_ready;
    logic           sqrt_start;
    logic [7:0]     sqrt_x;
    logic           sqrt_done;
    logic [7:0]     sqrt_y;
    logic           busy;
`ifdef SQRT_ARB_TIMEOUT_EN
    logic           resp_err;
`endif

    always #5 clock = ~clock;

    sqrt_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
`ifdef SQRT_ARB_TIMEOUT_EN
        .resp_err   (resp_err),
`endif
        .sqrt_start (sqrt_start),
        .sqrt_x     (sqrt_x),
        .sqrt_done  (sqrt_done),
        .sqrt_y     (sqrt_y),
        .busy       (busy)
    );

    typedef struct {
        int         idx;
        logic [7:0] val;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] xs [N];

    function automatic logic [7:0] ref_sqrt(input logic [7:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return 8'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input int idx, input logic [7:0] v);
        xs[idx] = v;
        req_x[8*idx +: 8] = v;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        sqrt_done  = 1'b0;
        sqrt_y     = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a negedge in IDLE with req_valid already driven; ends in cycle 1.
    task automatic accept(input int idx);
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(1) << idx);
        sb.push_back('{idx, ref_sqrt(xs[idx]), 1'b0});
        @(negedge clock);
        req_valid[idx] = 1'b0;
        chk("sqrt_start_pulse", 32'(sqrt_start), 32'd1);
        chk("sqrt_x_operand", 32'(sqrt_x), 32'(xs[idx]));
        chk("busy_issue", 32'(busy), 32'd1);
    endtask

    // Behavioural sqrt unit: answers lat cycles after the ISSUE cycle.
    task automatic unit_answer(input int lat);
        repeat (lat) begin
            @(negedge clock);
            chk("sqrt_start_low", 32'(sqrt_start), 32'd0);
            chk("resp_valid_wait", 32'(resp_valid), 32'd0);
        end
        sqrt_done = 1'b1;
        sqrt_y    = ref_sqrt(sqrt_x);
        @(negedge clock);
        sqrt_done = 1'b0;
        sqrt_y    = '0;
    endtask

    // Checks the pending response against the scoreboard, holds it for
    // `hold` cycles of backpressure, then completes the handshake.
    task automatic take_resp(input int hold);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("resp_valid_onehot", 32'(resp_valid), 32'(1) << e.idx);
        chk("resp_data", 32'(resp_data), 32'(e.val));
`ifdef SQRT_ARB_TIMEOUT_EN
        chk("resp_err", 32'(resp_err), 32'(e.err));
`endif
        for (int c = 0; c < hold; c++) begin
            resp_ready = ~(N'(1) << e.idx);
            @(negedge clock);
            chk("bp_resp_valid", 32'(resp_valid), 32'(1) << e.idx);
            chk("bp_resp_data", 32'(resp_data), 32'(e.val));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = N'(1) << e.idx;
        @(negedge clock);
        resp_ready = '0;
        chk("resp_valid_cleared", 32'(resp_valid), 32'd0);
        chk("busy_idle_after_resp", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        req_x = '0;
        for (int i = 0; i < N; i++) xs[i] = '0;
        do_reset();

        // Reset state
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_sqrt_start", 32'(sqrt_start), 32'd0);
        chk("rst_sqrt_x", 32'(sqrt_x), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);

        // Single request: requester 1, x=49
        set_x(1, 8'd49);
        req_valid = 4'b0010;
        accept(1);
        unit_answer(2);
        take_resp(0);

        // All four requesting after reset: grants 0,1,2,3 back to back
        do_reset();
        set_x(0, 8'd0);
        set_x(1, 8'd1);
        set_x(2, 8'd255);
        set_x(3, 8'd144);
        req_valid = 4'b1111;
        accept(0);
        unit_answer(1);
        take_resp(0);
        accept(1);
        unit_answer(3);
        take_resp(0);
        accept(2);
        unit_answer(1);
        take_resp(10);
        accept(3);
        unit_answer(2);
        take_resp(0);

        // Pointer wraps to 0 after requester 3
        set_x(0, 8'd200);
        req_valid = 4'b1111;
        accept(0);
        unit_answer(1);
        take_resp(0);

        // Reset while waiting: operation dropped, late done ignored
        req_valid = 4'b0000;
        set_x(3, 8'd100);
        req_valid = 4'b1000;
        #1;
        chk("rst_wait_grant", 32'(req_ready), 32'b1000);
        @(negedge clock);
        req_valid = 4'b0000;
        @(negedge clock);
        chk("rst_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_sqrt_start", 32'(sqrt_start), 32'd0);
        chk("midrst_sqrt_x", 32'(sqrt_x), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_data", 32'(resp_data), 32'd0);
        sqrt_done = 1'b1;
        sqrt_y    = 8'd10;
        @(negedge clock);
        sqrt_done = 1'b0;
        chk("idle_done_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_done_busy", 32'(busy), 32'd0);

        // Pointer back at 0 after reset; spurious done during ISSUE ignored
        set_x(0, 8'd225);
        set_x(3, 8'd100);
        req_valid = 4'b1001;
        accept(0);
        sqrt_done = 1'b1;
        sqrt_y    = 8'h55;
        @(negedge clock);
        sqrt_done = 1'b0;
        sqrt_y    = '0;
        chk("issue_done_resp_valid", 32'(resp_valid), 32'd0);
        chk("issue_done_busy", 32'(busy), 32'd1);
        unit_answer(1);
        take_resp(0);
        accept(3);
        unit_answer(2);
        take_resp(0);

`ifdef SQRT_ARB_TIMEOUT_EN
        // Unit never answers: response after 8 WAIT cycles with error
        set_x(0, 8'd81);
        req_valid = 4'b0001;
        #1;
        chk("to_grant", 32'(req_ready), 32'b0001);
        sb.push_back('{0, 8'd0, 1'b1});
        @(negedge clock);
        req_valid = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk("to_wait_no_resp", 32'(resp_valid), 32'd0);
        end
        @(negedge clock);
        take_resp(0);
        set_x(1, 8'd64);
        req_valid = 4'b0010;
        accept(1);
        unit_answer(1);
        take_resp(0);
`endif

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sqrt_arbiter
`default_nettype wire
